// File: rtl/prbs_ber_controller_pkg.sv
// Shared types and constants for the PRBS7 BER measurement controller.
package prbs_ber_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_SYNC    = 3'd2,
    ST_MEASURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int PRBS_WORD_BITS = 64;
  localparam int ERR_CNT_W      = 7;
  // A 64-bit word cannot carry more than 64 bit errors.
  localparam int MAX_WORD_ERR   = PRBS_WORD_BITS;

  function automatic logic [ERR_CNT_W-1:0] clamp_err(input logic [ERR_CNT_W-1:0] raw);
    if (raw > ERR_CNT_W'(MAX_WORD_ERR)) return ERR_CNT_W'(MAX_WORD_ERR);
    return raw;
  endfunction

endpackage

// File: rtl/prbs_ber_controller_accumulator.sv
// Per-word error accumulation: word count, saturating error total, worst word.
module ber_accumulator
  import prbs_ber_controller_pkg::*;
#(
  parameter int CNT_W = 48
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [ERR_CNT_W-1:0] err_in,
  output logic [ERR_CNT_W-1:0] err_clamped,
  output logic [CNT_W-1:0]     word_count,
  output logic [CNT_W-1:0]     err_total,
  output logic [ERR_CNT_W-1:0] max_err_word
);

  logic [CNT_W-1:0]     word_count_q, word_count_d;
  logic [CNT_W-1:0]     err_total_q, err_total_d;
  logic [ERR_CNT_W-1:0] max_err_q, max_err_d;
  logic [CNT_W:0]       sum;

  always_comb begin
    err_clamped  = clamp_err(err_in);
    sum          = {1'b0, err_total_q} + (CNT_W+1)'(err_clamped);
    word_count_d = word_count_q;
    err_total_d  = err_total_q;
    max_err_d    = max_err_q;
    if (clear) begin
      word_count_d = '0;
      err_total_d  = '0;
      max_err_d    = '0;
    end else if (enable) begin
      word_count_d = word_count_q + CNT_W'(1);
      // Carry out of the sum means the total has run past all-ones.
      err_total_d  = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      if (err_clamped > max_err_q) max_err_d = err_clamped;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count_q <= '0;
      err_total_q  <= '0;
      max_err_q    <= '0;
    end else begin
      word_count_q <= word_count_d;
      err_total_q  <= err_total_d;
      max_err_q    <= max_err_d;
    end
  end

  assign word_count   = word_count_q;
  assign err_total    = err_total_q;
  assign max_err_word = max_err_q;

endmodule

// File: rtl/prbs_ber_controller.sv
// Sequences a PRBS7 checker through flush, lock search and a windowed BER measurement.
module prbs_ber_controller
  import prbs_ber_controller_pkg::*;
#(
  parameter int FLUSH_CYCLES = 8,
  parameter int LOCK_WORDS   = 16,
  parameter int LOSS_THRESH  = 32,
  parameter int LOSS_WORDS   = 4,
  parameter int SYNC_TIMEOUT = 4096,
  parameter int CNT_W        = 48
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [31:0]          window_words,
  input  logic [ERR_CNT_W-1:0] err_count_in,
  output logic                 chk_reset,
  output logic                 busy,
  output logic                 locked,
  output logic                 done,
  output logic                 sync_fail,
  output logic [CNT_W-1:0]     word_count,
  output logic [CNT_W-1:0]     err_total,
  output logic [ERR_CNT_W-1:0] max_err_word,
  output logic [7:0]           lock_loss_count,
  output logic [2:0]           state
);

  localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
  localparam int LOCK_W  = $clog2(LOCK_WORDS + 1);
  localparam int LOSS_W  = $clog2(LOSS_WORDS + 1);
  localparam int TO_W    = $clog2(SYNC_TIMEOUT + 1);
  localparam int CMP_W   = (CNT_W > 32) ? CNT_W : 32;

  state_t               state_q, state_d;
  logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [LOCK_W-1:0]    zero_run_q, zero_run_d;
  logic [LOSS_W-1:0]    bad_run_q, bad_run_d;
  logic [TO_W-1:0]      timeout_q, timeout_d;
  logic [31:0]          window_q, window_d;
  logic [7:0]           lock_loss_q, lock_loss_d;
  logic                 sync_fail_q, sync_fail_d;
  logic                 chk_reset_q, chk_reset_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 locked_q, locked_d;
  logic                 acc_clear, acc_enable, window_hit, bad_word;
  logic [ERR_CNT_W-1:0] err_clamped;
  logic [CNT_W-1:0]     word_inc;

  ber_accumulator #(.CNT_W(CNT_W)) u_acc (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (acc_clear),
    .enable       (acc_enable),
    .err_in       (err_count_in),
    .err_clamped  (err_clamped),
    .word_count   (word_count),
    .err_total    (err_total),
    .max_err_word (max_err_word)
  );

  assign word_inc   = word_count + CNT_W'(1);
  assign window_hit = (window_q != '0) && (CMP_W'(word_inc) == CMP_W'(window_q));
  assign bad_word   = 32'(err_clamped) >= LOSS_THRESH;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    zero_run_d  = zero_run_q;
    bad_run_d   = bad_run_q;
    timeout_d   = timeout_q;
    window_d    = window_q;
    lock_loss_d = lock_loss_q;
    sync_fail_d = sync_fail_q;
    acc_clear   = 1'b0;
    acc_enable  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !stop) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
          acc_clear   = 1'b1;
          lock_loss_d = '0;
          sync_fail_d = 1'b0;
          window_d    = window_words;
        end
      end
      ST_FLUSH: begin
        zero_run_d = '0;
        bad_run_d  = '0;
        timeout_d  = '0;
        if (stop) state_d = ST_DONE;
        else if (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1)) state_d = ST_SYNC;
        else flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
      end
      ST_SYNC: begin
        bad_run_d  = '0;
        zero_run_d = (err_count_in == '0) ? zero_run_q + LOCK_W'(1) : '0;
        timeout_d  = timeout_q + TO_W'(1);
        if (stop) state_d = ST_DONE;
        else if (zero_run_d == LOCK_W'(LOCK_WORDS)) state_d = ST_MEASURE;
        else if (timeout_d == TO_W'(SYNC_TIMEOUT)) begin
          state_d     = ST_DONE;
          sync_fail_d = 1'b1;
        end
      end
      ST_MEASURE: begin
        // The word in this cycle is counted whatever the transition taken.
        acc_enable = 1'b1;
        bad_run_d  = bad_word ? bad_run_q + LOSS_W'(1) : '0;
        if (stop || window_hit) state_d = ST_DONE;
        else if (bad_run_d == LOSS_W'(LOSS_WORDS)) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
          if (lock_loss_q != 8'hFF) lock_loss_d = lock_loss_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    chk_reset_d = (state_d == ST_FLUSH) && (state_q != ST_FLUSH);
    done_d      = (state_d == ST_DONE) && (state_q != ST_DONE);
    busy_d      = (state_d == ST_FLUSH) || (state_d == ST_SYNC) || (state_d == ST_MEASURE);
    locked_d    = (state_d == ST_MEASURE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      zero_run_q  <= '0;
      bad_run_q   <= '0;
      timeout_q   <= '0;
      window_q    <= '0;
      lock_loss_q <= '0;
      sync_fail_q <= 1'b0;
      chk_reset_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      zero_run_q  <= zero_run_d;
      bad_run_q   <= bad_run_d;
      timeout_q   <= timeout_d;
      window_q    <= window_d;
      lock_loss_q <= lock_loss_d;
      sync_fail_q <= sync_fail_d;
      chk_reset_q <= chk_reset_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      locked_q    <= locked_d;
    end
  end

  assign state           = state_q;
  assign chk_reset       = chk_reset_q;
  assign done            = done_q;
  assign busy            = busy_q;
  assign locked          = locked_q;
  assign sync_fail       = sync_fail_q;
  assign lock_loss_count = lock_loss_q;

endmodule

// File: tb/tb_prbs_ber_controller.sv
// Directed bench for prbs_ber_controller; a narrow-counter second instance covers saturation.
module tb_prbs_ber_controller;

  logic        clk = 1'b0;
  logic        reset_n, start, stop;
  logic [31:0] window_words;
  logic [6:0]  err_count_in;

  logic        chk_reset, busy, locked, done, sync_fail;
  logic [47:0] word_count, err_total;
  logic [6:0]  max_err_word;
  logic [7:0]  lock_loss_count;
  logic [2:0]  state;

  logic        s_chk_reset, s_busy, s_locked, s_done, s_sync_fail;
  logic [11:0] s_word_count, s_err_total;
  logic [6:0]  s_max_err_word;
  logic [7:0]  s_lock_loss_count;
  logic [2:0]  s_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prbs_ber_controller dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .window_words(window_words), .err_count_in(err_count_in),
    .chk_reset(chk_reset), .busy(busy), .locked(locked), .done(done),
    .sync_fail(sync_fail), .word_count(word_count), .err_total(err_total),
    .max_err_word(max_err_word), .lock_loss_count(lock_loss_count), .state(state)
  );

  // 12-bit accumulators saturate quickly; threshold 65 means clamped words are never bad.
  prbs_ber_controller #(.CNT_W(12), .LOSS_THRESH(65)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .window_words(window_words), .err_count_in(err_count_in),
    .chk_reset(s_chk_reset), .busy(s_busy), .locked(s_locked), .done(s_done),
    .sync_fail(s_sync_fail), .word_count(s_word_count), .err_total(s_err_total),
    .max_err_word(s_max_err_word), .lock_loss_count(s_lock_loss_count), .state(s_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] target, input bit use_sat, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (((use_sat ? s_state : state) !== target) && (n < budget));
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; window_words = '0; err_count_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++;
    if ({chk_reset, busy, locked, done, sync_fail} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {chk_reset, busy, locked, done, sync_fail});
    end
    checks++;
    if (word_count !== 48'd0 || err_total !== 48'd0 || max_err_word !== 7'd0 || lock_loss_count !== 8'd0) begin
      failures++; $display("FAIL reset_counters wc=%0d et=%0d mx=%0d ll=%0d exp=0", word_count, err_total, max_err_word, lock_loss_count);
    end
    reset_n = 1'b1;
    tick();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (state !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL idle_start_stop state=%0d busy=%b exp=0/0", state, busy); end
    $display("test_reset: done");
  endtask

  task automatic test_clean_lock();
    int n, hi;
    window_words = 32'd1000; err_count_in = '0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (state !== 3'd1 || chk_reset !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL clean_flush_entry state=%0d chk_reset=%b busy=%b exp=1/1/1", state, chk_reset, busy);
    end
    n = 0; hi = 0;
    while (state !== 3'd2 && n < 20) begin
      tick();
      n++;
      if (chk_reset) hi++;
    end
    checks++;
    if (n !== 8 || hi !== 0) begin failures++; $display("FAIL clean_flush_len cycles=%0d chk_hi=%0d exp=8/0", n, hi); end
    wait_state(3'd3, 1'b0, 40, n);
    checks++;
    if (n !== 16 || locked !== 1'b1) begin failures++; $display("FAIL clean_lock cycles=%0d locked=%b exp=16/1", n, locked); end
    wait_state(3'd4, 1'b0, 1100, n);
    checks++;
    if (n !== 1000 || done !== 1'b1 || word_count !== 48'd1000 || err_total !== 48'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL clean_window cycles=%0d done=%b wc=%0d et=%0d busy=%b exp=1000/1/1000/0/0", n, done, word_count, err_total, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || state !== 3'd4 || word_count !== 48'd1000) begin
      failures++; $display("FAIL clean_hold done=%b state=%0d wc=%0d exp=0/4/1000", done, state, word_count);
    end
    $display("test_clean_lock: done");
  endtask

  task automatic test_constant_errors();
    int n;
    window_words = 32'd100; err_count_in = '0; start = 1'b1;
    tick();
    start = 1'b0;
    window_words = 32'd5;
    checks++;
    if (word_count !== 48'd0 || state !== 3'd1) begin failures++; $display("FAIL const_clear wc=%0d state=%0d exp=0/1", word_count, state); end
    wait_state(3'd3, 1'b0, 40, n);
    err_count_in = 7'd3;
    wait_state(3'd4, 1'b0, 200, n);
    checks++;
    if (n !== 100 || word_count !== 48'd100 || err_total !== 48'd300 || max_err_word !== 7'd3 || lock_loss_count !== 8'd0) begin
      failures++; $display("FAIL const_errors cycles=%0d wc=%0d et=%0d mx=%0d ll=%0d exp=100/100/300/3/0", n, word_count, err_total, max_err_word, lock_loss_count);
    end
    err_count_in = '0;
    $display("test_constant_errors: done");
  endtask

  task automatic test_lock_loss();
    int n;
    window_words = 32'd0; err_count_in = '0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(3'd3, 1'b0, 40, n);
    repeat (10) tick();
    err_count_in = 7'd40;
    repeat (3) tick();
    err_count_in = 7'd0;
    tick();
    checks++;
    if (state !== 3'd3 || lock_loss_count !== 8'd0) begin failures++; $display("FAIL loss_three_bad state=%0d ll=%0d exp=3/0", state, lock_loss_count); end
    err_count_in = 7'd40;
    repeat (3) tick();
    checks++;
    if (state !== 3'd3) begin failures++; $display("FAIL loss_early state=%0d exp=3", state); end
    tick();
    err_count_in = 7'd0;
    checks++;
    if (state !== 3'd1 || lock_loss_count !== 8'd1 || chk_reset !== 1'b1 || word_count !== 48'd18 || err_total !== 48'd280) begin
      failures++; $display("FAIL loss_event state=%0d ll=%0d chk=%b wc=%0d et=%0d exp=1/1/1/18/280", state, lock_loss_count, chk_reset, word_count, err_total);
    end
    wait_state(3'd2, 1'b0, 20, n);
    checks++;
    if (n !== 8) begin failures++; $display("FAIL loss_reflush cycles=%0d exp=8", n); end
    wait_state(3'd3, 1'b0, 40, n);
    checks++;
    if (n !== 16 || word_count !== 48'd18) begin failures++; $display("FAIL loss_relock cycles=%0d wc=%0d exp=16/18", n, word_count); end
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (state !== 3'd4 || done !== 1'b1 || word_count !== 48'd24 || err_total !== 48'd280 || max_err_word !== 7'd40) begin
      failures++; $display("FAIL loss_final state=%0d done=%b wc=%0d et=%0d mx=%0d exp=4/1/24/280/40", state, done, word_count, err_total, max_err_word);
    end
    $display("test_lock_loss: done");
  endtask

  task automatic test_sync_timeout();
    int n;
    bit e;
    window_words = 32'd0; err_count_in = '0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(3'd2, 1'b0, 20, n);
    n = 0; e = 1'b0;
    while (state !== 3'd4 && n < 5000) begin
      err_count_in = e ? 7'd1 : 7'd0;
      e = !e;
      tick();
      n++;
    end
    err_count_in = '0;
    checks++;
    if (n !== 4096 || sync_fail !== 1'b1 || word_count !== 48'd0 || done !== 1'b1) begin
      failures++; $display("FAIL sync_timeout cycles=%0d sync_fail=%b wc=%0d done=%b exp=4096/1/0/1", n, sync_fail, word_count, done);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (sync_fail !== 1'b0 || state !== 3'd1) begin failures++; $display("FAIL sync_fail_clear sf=%b state=%0d exp=0/1", sync_fail, state); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (state !== 3'd4 || done !== 1'b1) begin failures++; $display("FAIL flush_stop state=%0d done=%b exp=4/1", state, done); end
    $display("test_sync_timeout: done");
  endtask

  task automatic test_stop_window_end();
    int n, pulses;
    window_words = 32'd20; err_count_in = '0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(3'd3, 1'b0, 40, n);
    repeat (19) tick();
    checks++;
    if (state !== 3'd3 || word_count !== 48'd19) begin failures++; $display("FAIL win_pre state=%0d wc=%0d exp=3/19", state, word_count); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    pulses = done ? 1 : 0;
    checks++;
    if (state !== 3'd4 || word_count !== 48'd20) begin failures++; $display("FAIL win_stop state=%0d wc=%0d exp=4/20", state, word_count); end
    repeat (5) begin
      tick();
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 1) begin failures++; $display("FAIL win_single_done pulses=%0d exp=1", pulses); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (state !== 3'd4 || done !== 1'b0 || word_count !== 48'd20) begin
      failures++; $display("FAIL done_stop_ignored state=%0d done=%b wc=%0d exp=4/0/20", state, done, word_count);
    end
    $display("test_stop_window_end: done");
  endtask

  task automatic test_unlimited_stop();
    int n;
    window_words = 32'd0; err_count_in = '0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (state !== 3'd1 || chk_reset !== 1'b0) begin failures++; $display("FAIL busy_start state=%0d chk=%b exp=1/0", state, chk_reset); end
    wait_state(3'd2, 1'b0, 20, n);
    checks++;
    if (n !== 6) begin failures++; $display("FAIL busy_start_flush cycles=%0d exp=6", n); end
    wait_state(3'd3, 1'b0, 40, n);
    repeat (499) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (state !== 3'd4 || word_count !== 48'd500) begin failures++; $display("FAIL unlimited_stop state=%0d wc=%0d exp=4/500", state, word_count); end
    $display("test_unlimited_stop: done");
  endtask

  task automatic test_saturation_reset();
    int n;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    window_words = 32'd0; err_count_in = '0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(3'd3, 1'b1, 40, n);
    err_count_in = 7'd127;
    repeat (63) tick();
    checks++;
    if (s_err_total !== 12'd4032 || s_word_count !== 12'd63) begin
      failures++; $display("FAIL sat_pre et=%0d wc=%0d exp=4032/63", s_err_total, s_word_count);
    end
    tick();
    checks++;
    if (s_err_total !== 12'd4095) begin failures++; $display("FAIL sat_hit et=%0d exp=4095", s_err_total); end
    repeat (6) tick();
    checks++;
    if (s_err_total !== 12'd4095 || s_word_count !== 12'd70 || s_max_err_word !== 7'd64 || s_state !== 3'd3) begin
      failures++; $display("FAIL sat_hold et=%0d wc=%0d mx=%0d state=%0d exp=4095/70/64/3", s_err_total, s_word_count, s_max_err_word, s_state);
    end
    checks++;
    if (err_total !== 48'd256 || word_count !== 48'd4 || max_err_word !== 7'd64 || lock_loss_count !== 8'd1) begin
      failures++; $display("FAIL clamp_127 et=%0d wc=%0d mx=%0d ll=%0d exp=256/4/64/1", err_total, word_count, max_err_word, lock_loss_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (s_state !== 3'd0 || s_word_count !== 12'd0 || s_err_total !== 12'd0 || s_max_err_word !== 7'd0 ||
        {s_chk_reset, s_busy, s_locked, s_done, s_sync_fail} !== 5'b0 || s_lock_loss_count !== 8'd0) begin
      failures++; $display("FAIL async_reset_sat state=%0d wc=%0d et=%0d exp=0/0/0", s_state, s_word_count, s_err_total);
    end
    checks++;
    if (state !== 3'd0 || word_count !== 48'd0 || err_total !== 48'd0 || lock_loss_count !== 8'd0 ||
        {chk_reset, busy, locked, done, sync_fail} !== 5'b0) begin
      failures++; $display("FAIL async_reset_main state=%0d wc=%0d et=%0d ll=%0d exp=0/0/0/0", state, word_count, err_total, lock_loss_count);
    end
    err_count_in = '0;
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL post_reset_idle state=%0d exp=0", state); end
    $display("test_saturation_reset: done");
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_constant_errors();
    test_lock_loss();
    test_sync_timeout();
    test_stop_window_end();
    test_unlimited_stop();
    test_saturation_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
